// File: rtl/rf_write_buffer.sv
// Posted-write queue in front of a register-file write port, with read bypass
// of pending and in-flight writes.
module rf_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     in_valid,
    input  logic [4:0]               in_wr,
    input  logic [31:0]              in_wd,
    output logic                     in_ready,
    input  logic                     rf_busy,
    output logic                     rf_write,
    output logic [4:0]               rf_wr,
    output logic [31:0]              rf_wd,
    input  logic [4:0]               PR1,
    input  logic [4:0]               PR2,
    output logic                     byp1_hit,
    output logic                     byp2_hit,
    output logic [31:0]              byp1_data,
    output logic [31:0]              byp2_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [4:0]    wr_mem_r [DEPTH];
    logic [31:0]   wd_mem_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          rf_write_r;
    logic [4:0]    rf_wr_r;
    logic [31:0]   rf_wd_r;

    logic          in_ready_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic [32:0]   byp1_s;
    logic [32:0]   byp2_s;

    // Youngest pending write to pr wins: output register first, then queue oldest to newest.
    function automatic logic [32:0] bypass_lookup(input logic [4:0] pr);
        logic          hit;
        logic [31:0]   data;
        logic [AW-1:0] idx;
        hit  = 1'b0;
        data = 32'h0000_0000;
        if (rf_write_r && (rf_wr_r == pr)) begin
            hit  = 1'b1;
            data = rf_wd_r;
        end else begin
            hit  = 1'b0;
            data = 32'h0000_0000;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_r + AW'(i);
            if ((CW'(i) < count_r) && (wr_mem_r[idx] == pr)) begin
                hit  = 1'b1;
                data = wd_mem_r[idx];
            end else begin
                hit  = hit;
                data = data;
            end
        end
        if (pr == 5'd0) begin
            hit  = 1'b0;
            data = 32'h0000_0000;
        end else begin
            hit  = hit;
            data = data;
        end
        return {hit, data};
    endfunction

    // Handshake and queue movement decisions from pre-edge state.
    always_comb begin
        in_ready_s = (count_r < DEPTH_C);
        accept_s   = in_valid && in_ready_s;
        push_s     = accept_s && (in_wr != 5'd0);
        pop_s      = (count_r != {CW{1'b0}}) && !rf_busy;
    end

    // Bypass lookups for both read ports.
    always_comb begin
        byp1_s = bypass_lookup(PR1);
        byp2_s = bypass_lookup(PR2);
    end

    // Entry storage; never reset, validity comes from head/count.
    always_ff @(posedge Clk) begin
        if (push_s) begin
            wr_mem_r[tail_r] <= in_wr;
            wd_mem_r[tail_r] <= in_wd;
        end
    end

    // Pointers, occupancy and the registered write port.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            head_r     <= {AW{1'b0}};
            tail_r     <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            rf_write_r <= 1'b0;
            rf_wr_r    <= 5'd0;
            rf_wd_r    <= 32'h0000_0000;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + AW'(1);
            end
            if (pop_s) begin
                head_r     <= head_r + AW'(1);
                rf_write_r <= 1'b1;
                rf_wr_r    <= wr_mem_r[head_r];
                rf_wd_r    <= wd_mem_r[head_r];
            end else begin
                rf_write_r <= 1'b0;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign rf_write  = rf_write_r;
    assign rf_wr     = rf_wr_r;
    assign rf_wd     = rf_wd_r;
    assign byp1_hit  = byp1_s[32];
    assign byp1_data = byp1_s[31:0];
    assign byp2_hit  = byp2_s[32];
    assign byp2_data = byp2_s[31:0];
    assign count     = count_r;
    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == {CW{1'b0}});

endmodule

// File: tb/tb_rf_write_buffer.sv
// Directed self-checking bench for rf_write_buffer (DEPTH=4).
module tb_rf_write_buffer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic [4:0]  in_wr;
    logic [31:0] in_wd;
    logic        in_ready;
    logic        rf_busy;
    logic        rf_write;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;
    logic [4:0]  PR1;
    logic [4:0]  PR2;
    logic        byp1_hit;
    logic        byp2_hit;
    logic [31:0] byp1_data;
    logic [31:0] byp2_data;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int errors = 0;
    int checks = 0;

    rf_write_buffer #(.DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_wr(in_wr), .in_wd(in_wd),
        .in_ready(in_ready), .rf_busy(rf_busy), .rf_write(rf_write), .rf_wr(rf_wr),
        .rf_wd(rf_wd), .PR1(PR1), .PR2(PR2), .byp1_hit(byp1_hit), .byp2_hit(byp2_hit),
        .byp1_data(byp1_data), .byp2_data(byp2_data), .count(count), .full(full),
        .empty(empty)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; in_valid = 1'b0; in_wr = 5'd0; in_wd = 32'h0;
        rf_busy = 1'b0; PR1 = 5'd5; PR2 = 5'd0;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rf_write", 32'(rf_write), 32'd0);
        chk("rst_rf_wr", 32'(rf_wr), 32'd0);
        chk("rst_rf_wd", rf_wd, 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_byp1_hit", 32'(byp1_hit), 32'd0);
        tick(); tick();

        // Single write; first push at first edge after release
        Reset = 1'b0; in_valid = 1'b1; in_wr = 5'd5; in_wd = 32'hDEAD0005;
        tick();
        in_valid = 1'b0;
        chk("single_count1", 32'(count), 32'd1);
        chk("single_no_same_cycle", 32'(rf_write), 32'd0);
        tick();
        chk("single_write", 32'(rf_write), 32'd1);
        chk("single_wr", 32'(rf_wr), 32'd5);
        chk("single_wd", rf_wd, 32'hDEAD0005);
        chk("single_count0", 32'(count), 32'd0);
        tick();
        chk("single_write_off", 32'(rf_write), 32'd0);
        chk("single_wr_hold", 32'(rf_wr), 32'd5);
        chk("single_count_end", 32'(count), 32'd0);

        // Register 0 accepted and dropped
        in_valid = 1'b1; in_wr = 5'd0; in_wd = 32'h1234;
        #1;
        chk("r0_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("r0_count", 32'(count), 32'd0);
        chk("r0_empty", 32'(empty), 32'd1);
        chk("r0_write", 32'(rf_write), 32'd0);
        tick();
        chk("r0_write2", 32'(rf_write), 32'd0);

        // Fill with rf_busy, then drain with wrap
        rf_busy = 1'b1; in_valid = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            in_wr = 5'(r); in_wd = 32'h100 + 32'(r);
            tick();
        end
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_write", 32'(rf_write), 32'd0);
        rf_busy = 1'b0; in_wr = 5'd5; in_wd = 32'h105;
        #1;
        chk("full_ready_with_pop", 32'(in_ready), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("drain_write", 32'(rf_write), 32'd1);
            chk("drain_wr", 32'(rf_wr), 32'(k));
            chk("drain_wd", rf_wd, 32'h100 + 32'(k));
            chk("drain_count", 32'(count), (k <= 5) ? 32'd3 : 32'(8 - k));
            if (k <= 4) begin
                in_wr = 5'(k + 4); in_wd = 32'h100 + 32'(k + 4);
            end else begin
                in_valid = 1'b0;
            end
        end
        tick();
        chk("drain_done_write", 32'(rf_write), 32'd0);
        chk("drain_done_empty", 32'(empty), 32'd1);

        // Bypass priority among queued writes and output register
        rf_busy = 1'b1; in_valid = 1'b1; in_wr = 5'd7; in_wd = 32'hA;
        tick();
        in_wd = 32'hB;
        tick();
        in_valid = 1'b0; PR1 = 5'd7; PR2 = 5'd0;
        #1;
        chk("byp_youngest_hit", 32'(byp1_hit), 32'd1);
        chk("byp_youngest_data", byp1_data, 32'hB);
        chk("byp_r0_hit", 32'(byp2_hit), 32'd0);
        chk("byp_r0_data", byp2_data, 32'd0);
        rf_busy = 1'b0;
        tick();
        chk("byp_q_over_out_wr", 32'(rf_wr), 32'd7);
        chk("byp_q_over_out", byp1_data, 32'hB);
        tick();
        chk("byp_out_hit", 32'(byp1_hit), 32'd1);
        chk("byp_out_data", byp1_data, 32'hB);
        tick();
        chk("byp_gone_hit", 32'(byp1_hit), 32'd0);
        chk("byp_gone_data", byp1_data, 32'd0);

        // Output-register bypass on port 2
        in_valid = 1'b1; in_wr = 5'd9; in_wd = 32'h99; PR2 = 5'd9;
        tick();
        in_valid = 1'b0;
        tick();
        chk("obyp_write", 32'(rf_write), 32'd1);
        chk("obyp_hit", 32'(byp2_hit), 32'd1);
        chk("obyp_data", byp2_data, 32'h99);
        tick();
        chk("obyp_after_hit", 32'(byp2_hit), 32'd0);

        // rf_busy holds queue and output registers
        rf_busy = 1'b1; in_valid = 1'b1;
        for (int r = 11; r <= 13; r++) begin
            in_wr = 5'(r); in_wd = 32'hC00 + 32'(r);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("busy_count", 32'(count), 32'd3);
        chk("busy_write", 32'(rf_write), 32'd0);
        chk("busy_wr_hold", 32'(rf_wr), 32'd9);
        chk("busy_wd_hold", rf_wd, 32'h99);

        // Async reset mid-operation
        rf_busy = 1'b0; PR1 = 5'd12; PR2 = 5'd11;
        tick();
        chk("pre_rst_write", 32'(rf_write), 32'd1);
        chk("pre_rst_wr", 32'(rf_wr), 32'd11);
        chk("pre_rst_count", 32'(count), 32'd2);
        #1;
        Reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_write", 32'(rf_write), 32'd0);
        chk("arst_wr", 32'(rf_wr), 32'd0);
        chk("arst_byp1", 32'(byp1_hit), 32'd0);
        chk("arst_byp2", 32'(byp2_hit), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        tick();
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_no_write", 32'(rf_write), 32'd0);
            chk("post_rst_byp1", 32'(byp1_hit), 32'd0);
        end
        in_valid = 1'b1; in_wr = 5'd20; in_wd = 32'h2020;
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_rst_push_write", 32'(rf_write), 32'd1);
        chk("post_rst_push_wr", 32'(rf_wr), 32'd20);
        chk("post_rst_push_wd", rf_wd, 32'h2020);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_write_buffer.md
RF_WRITE_BUFFER -- requirements
Module: rf_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 Clk  in  1  clock; all state updates on posedge Clk.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  producer has a write request.
REQ-005 in_wr  in  5  destination register index.
REQ-006 in_wd  in  32  write data.
REQ-007 in_ready  out  1  buffer can accept; combinational = (count < DEPTH).
REQ-008 rf_busy  in  1  register file cannot take a write this cycle.
REQ-009 rf_write  out  1  write strobe to register file Write port; registered.
REQ-010 rf_wr  out  5  register index to register file WR port; registered.
REQ-011 rf_wd  out  32  data to register file WD port; registered.
REQ-012 PR1, PR2  in  5 each  read indices, mirroring register file read ports.
REQ-013 byp1_hit, byp2_hit  out  1 each  pending write exists for PR1/PR2; combinational.
REQ-014 byp1_data, byp2_data  out  32 each  newest pending data for PR1/PR2; combinational.
REQ-015 count  out  $clog2(DEPTH)+1  occupied entries; registered.
REQ-016 full, empty  out  1 each  count==DEPTH, count==0.

Function
REQ-017 Circular FIFO with head/tail pointers mod DEPTH; wrap from DEPTH-1 to 0 is seamless.
REQ-018 Push on posedge when in_valid && in_ready && in_wr!=0: {in_wr,in_wd} stored at tail, tail+1.
REQ-019 in_valid && in_ready && in_wr==0 is accepted (handshake completes) and discarded; no entry stored.
REQ-020 in_valid && !in_ready: no state change; producer holds request.
REQ-021 Pop on posedge when !empty && !rf_busy (pre-edge values): head entry loaded into rf_wr/rf_wd, rf_write<=1, head+1.
REQ-022 No pop on an edge: rf_write<=0, rf_wr/rf_wd hold.
REQ-023 One pop per cycle maximum; entries leave strictly in acceptance order.
REQ-024 Latency: entry accepted at edge E into empty buffer with rf_busy=0 gives rf_write=1 with that entry between edges E+1 and E+2.
REQ-025 A push never pops in the same cycle; an empty buffer shows rf_write=0 for at least one cycle after a push.
REQ-026 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-027 When full, in_ready=0 even if a pop occurs that edge.
REQ-028 rf_busy high holds the queue; count and the rf_* registers retain their values except rf_write<=0.
REQ-029 Bypass set per port: queue entries plus the output register while rf_write=1.
REQ-030 Bypass: hit=1 if any set member matches PRx; data from the youngest match (tail-most queue entry, then output register).
REQ-031 PRx==0: hit=0, data=0. No match: hit=0, data=0.
REQ-032 count is a register updated as count + push - pop; never exceeds DEPTH, never underflows.

Reset
REQ-033 Reset high: immediately head=0, tail=0, count=0, rf_write=0, rf_wr=0, rf_wd=0; empty=1, full=0, in_ready=1.
REQ-034 Entry storage is not cleared; entries become invalid, and byp*_hit=0 while count=0 and rf_write=0.
REQ-035 Reset mid-operation discards all pending entries and any in-flight rf_write, with no partial write.
REQ-036 First push is accepted at the first posedge after Reset falls.

Verification
REQ-037 Single write: push {5,0xDEAD0005} into empty buffer with rf_busy=0 -> next cycle rf_write=1, rf_wr=5, rf_wd=0xDEAD0005; following cycle rf_write=0, count=0.
REQ-038 Fill and wrap: rf_busy=1, push regs 1..4 -> full=1, in_ready=0; rf_busy=0, push 5..8 as space frees -> rf_wr sequence 1..8 in order, no loss or duplication.
REQ-039 Bypass priority: rf_busy=1, push {7,0xA}, then {7,0xB}, PR1=7 -> byp1_hit=1, byp1_data=0xB; PR2=0 -> byp2_hit=0, byp2_data=0.
REQ-040 Output-register bypass: single entry {9,0x99} draining, PR2=9 while rf_write=1 -> byp2_hit=1, byp2_data=0x99; next cycle byp2_hit=0.
REQ-041 Register 0: push {0,0x1234} -> in_ready handshake completes, count stays 0, rf_write never asserts.
REQ-042 Async reset: 3 entries pending, Reset asserted mid-cycle -> count=0, rf_write=0, all byp hits 0 before the next edge; no stale entry is ever written after release.
